spc_ram_arbiter: RTL and testbench

Arbiter sharing the single-port 64 KiB audio RAM between the DSP voice fetch path (read-only) and the SPC700 CPU bus (read/write). Sits between the DSP's RAM port, the CPU memory interface and the RAM macro. Issues at most one RAM access per clock, registers the RAM command, and tags each read so returned data is steered to the requester that issued it. The DSP has priority; a starvation counter bounds CPU wait time.

---
 rtl/spc_ram_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_spc_ram_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spc_ram_arbiter.sv
// spc_ram_arbiter: shares the single-port audio RAM between the DSP voice
// fetch path (read-only, priority) and the SPC700 CPU bus (read/write).
// One RAM access per clock, registered RAM command, and a 2-bit owner tag
// that follows each read so the returned data is flagged to its requester.
// A saturating starvation counter lets the CPU win contention after
// CPU_STARVE_LIMIT consecutive denied cycles.
// Optional build macro SPC_RAM_ARB_STATS_EN adds stall/access statistics.
module spc_ram_arbiter #(
  parameter int ADDR_W           = 16,
  parameter int DATA_W           = 8,
  parameter int CPU_STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dsp_req,
  input  logic [ADDR_W-1:0] dsp_addr,
  output logic              dsp_gnt,
  output logic              dsp_rdata_valid,
  output logic [DATA_W-1:0] dsp_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rdata_valid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_write_enable,
`ifdef SPC_RAM_ARB_STATS_EN
  input  logic              stats_clear,
  output logic [15:0]       cpu_stall_cycles,
  output logic [15:0]       dsp_access_count,
`endif
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_DSP  = 2'd1;
  localparam logic [1:0] TAG_CPU  = 2'd2;
  localparam logic [3:0] STARVE_LIMIT = 4'(CPU_STARVE_LIMIT);

  logic              dsp_gnt_s;
  logic              cpu_gnt_s;
  logic              cpu_wins_s;

  logic [3:0]        starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [1:0]        tag_q, tag_d;
  logic              dsp_valid_q, dsp_valid_d;
  logic              cpu_valid_q, cpu_valid_d;

  // Grant decision: DSP first unless the CPU has been starved long enough;
  // nothing is granted while reset is held low.
  always_comb begin
    cpu_wins_s = 1'b0;
    dsp_gnt_s  = 1'b0;
    cpu_gnt_s  = 1'b0;
    if (!reset) begin
      cpu_wins_s = 1'b0;
      dsp_gnt_s  = 1'b0;
      cpu_gnt_s  = 1'b0;
    end else begin
      cpu_wins_s = (starve_q >= STARVE_LIMIT);
      if (dsp_req && cpu_req) begin
        dsp_gnt_s = ~cpu_wins_s;
        cpu_gnt_s = cpu_wins_s;
      end else begin
        dsp_gnt_s = dsp_req;
        cpu_gnt_s = cpu_req;
      end
    end
  end

  assign dsp_gnt = dsp_gnt_s;
  assign cpu_gnt = cpu_gnt_s;

  // Starvation counter: counts denied CPU cycles, saturating at 15.
  always_comb begin
    starve_d = starve_q;
    if (!cpu_req) begin
      starve_d = 4'd0;
    end else if (cpu_gnt_s) begin
      starve_d = 4'd0;
    end else if (starve_q != 4'hF) begin
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  // Command stage next state: load the granted access, or idle with the
  // address held and write enable dropped.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    tag_d   = TAG_NONE;
    if (dsp_gnt_s) begin
      addr_d = dsp_addr;
      we_d   = 1'b0;
      tag_d  = TAG_DSP;
    end else if (cpu_gnt_s) begin
      addr_d  = cpu_addr;
      wdata_d = cpu_wdata;
      we_d    = cpu_we;
      tag_d   = cpu_we ? TAG_NONE : TAG_CPU;
    end else begin
      we_d  = 1'b0;
      tag_d = TAG_NONE;
    end
  end

  // Return stage next state: the command tag becomes a valid pulse one
  // cycle later, when the RAM's synchronous read data appears.
  always_comb begin
    dsp_valid_d = 1'b0;
    cpu_valid_d = 1'b0;
    case (tag_q)
      TAG_DSP: dsp_valid_d = 1'b1;
      TAG_CPU: cpu_valid_d = 1'b1;
      default: begin
        dsp_valid_d = 1'b0;
        cpu_valid_d = 1'b0;
      end
    endcase
  end

  // Pipeline registers; reset discards any in-flight command and tags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_q    <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      tag_q       <= TAG_NONE;
      dsp_valid_q <= 1'b0;
      cpu_valid_q <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      tag_q       <= tag_d;
      dsp_valid_q <= dsp_valid_d;
      cpu_valid_q <= cpu_valid_d;
    end
  end

  assign ram_address      = addr_q;
  assign ram_wdata        = wdata_q;
  assign ram_write_enable = we_q;
  assign dsp_rdata_valid  = dsp_valid_q;
  assign cpu_rdata_valid  = cpu_valid_q;
  assign dsp_rdata        = ram_rdata;
  assign cpu_rdata        = ram_rdata;

`ifdef SPC_RAM_ARB_STATS_EN
  logic [15:0] stall_q, stall_d;
  logic [15:0] dacc_q, dacc_d;

  // Statistics next state: clear wins over increment; both saturate.
  always_comb begin
    stall_d = stall_q;
    dacc_d  = dacc_q;
    if (stats_clear) begin
      stall_d = 16'd0;
      dacc_d  = 16'd0;
    end else begin
      if (cpu_req && !cpu_gnt_s && (stall_q != 16'hFFFF)) begin
        stall_d = stall_q + 16'd1;
      end else begin
        stall_d = stall_q;
      end
      if (dsp_gnt_s && (dacc_q != 16'hFFFF)) begin
        dacc_d = dacc_q + 16'd1;
      end else begin
        dacc_d = dacc_q;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q <= 16'd0;
      dacc_q  <= 16'd0;
    end else begin
      stall_q <= stall_d;
      dacc_q  <= dacc_d;
    end
  end

  assign cpu_stall_cycles = stall_q;
  assign dsp_access_count = dacc_q;
`endif

endmodule

// File: tb/tb_spc_ram_arbiter.sv
// Directed self-checking bench for spc_ram_arbiter with a write-first
// synchronous RAM model behind the arbiter.
`timescale 1ns/1ps
module tb_spc_ram_arbiter;

  logic        clock;
  logic        reset;
  logic        dsp_req;
  logic [15:0] dsp_addr;
  logic        dsp_gnt;
  logic        dsp_rdata_valid;
  logic [7:0]  dsp_rdata;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_rdata_valid;
  logic [7:0]  cpu_rdata;
  logic [15:0] ram_address;
  logic [7:0]  ram_wdata;
  logic        ram_write_enable;
  logic [7:0]  ram_rdata;
`ifdef SPC_RAM_ARB_STATS_EN
  logic        stats_clear;
  logic [15:0] cpu_stall_cycles;
  logic [15:0] dsp_access_count;
`endif

  int total;
  int bad;

  // RAM model with a preload port for setting up contents
  logic [7:0]  mem [0:65535];
  logic        pre_we;
  logic [15:0] pre_addr;
  logic [7:0]  pre_data;

  // Protocol tracking: request pending and not granted in the last cycle
  logic        pend_d;
  logic        pend_c;
  logic [15:0] snap_daddr;
  logic [15:0] snap_caddr;
  logic        snap_cwe;
  logic [7:0]  snap_cwdata;

  spc_ram_arbiter #(.ADDR_W(16), .DATA_W(8), .CPU_STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .dsp_req(dsp_req), .dsp_addr(dsp_addr), .dsp_gnt(dsp_gnt),
    .dsp_rdata_valid(dsp_rdata_valid), .dsp_rdata(dsp_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
    .cpu_rdata_valid(cpu_rdata_valid), .cpu_rdata(cpu_rdata),
    .ram_address(ram_address), .ram_wdata(ram_wdata),
    .ram_write_enable(ram_write_enable),
`ifdef SPC_RAM_ARB_STATS_EN
    .stats_clear(stats_clear), .cpu_stall_cycles(cpu_stall_cycles),
    .dsp_access_count(dsp_access_count),
`endif
    .ram_rdata(ram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Write-first single-port synchronous RAM
  always @(posedge clock) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (ram_write_enable) begin
      mem[ram_address] <= ram_wdata;
    end
    ram_rdata <= ram_write_enable ? ram_wdata : mem[ram_address];
  end

  // Advance one clock; also flags requesters that change a held request
  task automatic step();
    if (pend_d && dsp_req) begin
      total++;
      if (dsp_addr !== snap_daddr) begin
        bad++;
        $display("FAIL proto_dsp: addr changed to %h while waiting, held %h", dsp_addr, snap_daddr);
      end
    end
    if (pend_c && cpu_req) begin
      total++;
      if ({cpu_addr, cpu_we, cpu_wdata} !== {snap_caddr, snap_cwe, snap_cwdata}) begin
        bad++;
        $display("FAIL proto_cpu: addr/we/wdata changed to %h/%b/%h while waiting", cpu_addr, cpu_we, cpu_wdata);
      end
    end
    pend_d      = dsp_req & ~dsp_gnt;
    pend_c      = cpu_req & ~cpu_gnt;
    snap_daddr  = dsp_addr;
    snap_caddr  = cpu_addr;
    snap_cwe    = cpu_we;
    snap_cwdata = cpu_wdata;
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    step();
    pre_we   = 1'b0;
  endtask

  task automatic test_reset();
    dsp_req = 1'b1;
    cpu_req = 1'b1;
    #1;
    total++;
    if ({dsp_gnt, cpu_gnt} !== 2'b00) begin
      bad++;
      $display("FAIL reset_gnt: got %b, want 00", {dsp_gnt, cpu_gnt});
    end
    total++;
    if (ram_address !== 16'h0000 || ram_wdata !== 8'h00 || ram_write_enable !== 1'b0) begin
      bad++;
      $display("FAIL reset_cmd: got addr=%h wdata=%h we=%b, want 0000/00/0", ram_address, ram_wdata, ram_write_enable);
    end
    total++;
    if ({dsp_rdata_valid, cpu_rdata_valid} !== 2'b00) begin
      bad++;
      $display("FAIL reset_valid: got %b, want 00", {dsp_rdata_valid, cpu_rdata_valid});
    end
    dsp_req = 1'b0;
    cpu_req = 1'b0;
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_dsp_read();
    dsp_req  = 1'b1;
    dsp_addr = 16'h1234;
    #1;
    total++;
    if ({dsp_gnt, cpu_gnt} !== 2'b10) begin
      bad++;
      $display("FAIL dsp_gnt: got %b, want 10", {dsp_gnt, cpu_gnt});
    end
    step();
    dsp_req = 1'b0;
    #1;
    total++;
    if (ram_address !== 16'h1234 || ram_write_enable !== 1'b0 || dsp_rdata_valid !== 1'b0) begin
      bad++;
      $display("FAIL dsp_cmd: got addr=%h we=%b valid=%b, want 1234/0/0", ram_address, ram_write_enable, dsp_rdata_valid);
    end
    step();
    total++;
    if (dsp_rdata_valid !== 1'b1 || dsp_rdata !== 8'h5A || cpu_rdata_valid !== 1'b0) begin
      bad++;
      $display("FAIL dsp_ret: got valid=%b data=%h cpu_valid=%b, want 1/5a/0", dsp_rdata_valid, dsp_rdata, cpu_rdata_valid);
    end
    step();
    total++;
    if (dsp_rdata_valid !== 1'b0) begin
      bad++;
      $display("FAIL dsp_pulse: valid still %b, want 0", dsp_rdata_valid);
    end
  endtask

  task automatic test_cpu_write_read();
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 16'h00F0;
    cpu_wdata = 8'hC3;
    #1;
    total++;
    if ({dsp_gnt, cpu_gnt} !== 2'b01) begin
      bad++;
      $display("FAIL wr_gnt: got %b, want 01", {dsp_gnt, cpu_gnt});
    end
    step();
    cpu_we = 1'b0;
    #1;
    total++;
    if (ram_write_enable !== 1'b1 || ram_address !== 16'h00F0 || ram_wdata !== 8'hC3 || cpu_gnt !== 1'b1) begin
      bad++;
      $display("FAIL wr_cmd: got we=%b addr=%h wdata=%h gnt=%b, want 1/00f0/c3/1", ram_write_enable, ram_address, ram_wdata, cpu_gnt);
    end
    step();
    cpu_req = 1'b0;
    #1;
    total++;
    if (ram_write_enable !== 1'b0 || ram_address !== 16'h00F0 || cpu_rdata_valid !== 1'b0) begin
      bad++;
      $display("FAIL rd_cmd: got we=%b addr=%h valid=%b, want 0/00f0/0", ram_write_enable, ram_address, cpu_rdata_valid);
    end
    step();
    total++;
    if (cpu_rdata_valid !== 1'b1 || cpu_rdata !== 8'hC3 || dsp_rdata_valid !== 1'b0) begin
      bad++;
      $display("FAIL raw_ret: got valid=%b data=%h dsp_valid=%b, want 1/c3/0", cpu_rdata_valid, cpu_rdata, dsp_rdata_valid);
    end
    total++;
    if (mem[16'h00F0] !== 8'hC3) begin
      bad++;
      $display("FAIL wr_mem: got %h, want c3", mem[16'h00F0]);
    end
    step();
    total++;
    if (cpu_rdata_valid !== 1'b0 || ram_write_enable !== 1'b0) begin
      bad++;
      $display("FAIL wr_pulse: got valid=%b we=%b, want 0/0", cpu_rdata_valid, ram_write_enable);
    end
  endtask

  task automatic test_starvation();
    logic own_d [0:11];
    logic own_c [0:11];
`ifdef SPC_RAM_ARB_STATS_EN
    stats_clear = 1'b1;
    step();
    stats_clear = 1'b0;
`endif
    dsp_addr = 16'h0040;
    cpu_addr = 16'h0050;
    cpu_we   = 1'b0;
    for (int i = 0; i < 12; i++) begin
      dsp_req  = (i < 10);
      cpu_req  = (i < 10);
      own_d[i] = (i < 10) && ((i % 5) != 4);
      own_c[i] = (i < 10) && ((i % 5) == 4);
      #1;
      total++;
      if ({dsp_gnt, cpu_gnt} !== {own_d[i], own_c[i]}) begin
        bad++;
        $display("FAIL starve_gnt[%0d]: got %b, want %b", i, {dsp_gnt, cpu_gnt}, {own_d[i], own_c[i]});
      end
      if (i >= 2) begin
        total++;
        if ({dsp_rdata_valid, cpu_rdata_valid} !== {own_d[i-2], own_c[i-2]}) begin
          bad++;
          $display("FAIL starve_valid[%0d]: got %b, want %b", i, {dsp_rdata_valid, cpu_rdata_valid}, {own_d[i-2], own_c[i-2]});
        end
        if (own_d[i-2] || own_c[i-2]) begin
          total++;
          if (ram_rdata !== (own_d[i-2] ? 8'hA4 : 8'hB5)) begin
            bad++;
            $display("FAIL starve_data[%0d]: got %h, want %h", i, ram_rdata, own_d[i-2] ? 8'hA4 : 8'hB5);
          end
        end
      end
`ifdef SPC_RAM_ARB_STATS_EN
      if (i == 10) begin
        total++;
        if (cpu_stall_cycles !== 16'd8 || dsp_access_count !== 16'd8) begin
          bad++;
          $display("FAIL stats: got stall=%0d dsp=%0d, want 8/8", cpu_stall_cycles, dsp_access_count);
        end
      end
`endif
      step();
    end
`ifdef SPC_RAM_ARB_STATS_EN
    stats_clear = 1'b1;
    step();
    stats_clear = 1'b0;
    total++;
    if (cpu_stall_cycles !== 16'd0 || dsp_access_count !== 16'd0) begin
      bad++;
      $display("FAIL stats_clear: got stall=%0d dsp=%0d, want 0/0", cpu_stall_cycles, dsp_access_count);
    end
`endif
  endtask

  task automatic test_alternating();
    logic [15:0] a_d [0:4];
    logic [1:0]  who [0:4];
    logic [1:0]  vexp [0:4];
    logic [7:0]  dexp [0:4];
    who[0] = 2'b10; who[1] = 2'b01; who[2] = 2'b10; who[3] = 2'b00; who[4] = 2'b00;
    a_d[0] = 16'h0010; a_d[1] = 16'h0020; a_d[2] = 16'h0030; a_d[3] = 16'h0000; a_d[4] = 16'h0000;
    vexp[0] = 2'b00; vexp[1] = 2'b00; vexp[2] = 2'b10; vexp[3] = 2'b01; vexp[4] = 2'b10;
    dexp[0] = 8'h00; dexp[1] = 8'h00; dexp[2] = 8'h11; dexp[3] = 8'h22; dexp[4] = 8'h33;
    cpu_we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      dsp_req  = who[i][1];
      cpu_req  = who[i][0];
      dsp_addr = a_d[i];
      cpu_addr = a_d[i];
      #1;
      total++;
      if ({dsp_gnt, cpu_gnt} !== who[i]) begin
        bad++;
        $display("FAIL alt_gnt[%0d]: got %b, want %b", i, {dsp_gnt, cpu_gnt}, who[i]);
      end
      total++;
      if ({dsp_rdata_valid, cpu_rdata_valid} !== vexp[i]) begin
        bad++;
        $display("FAIL alt_valid[%0d]: got %b, want %b", i, {dsp_rdata_valid, cpu_rdata_valid}, vexp[i]);
      end
      if (vexp[i] != 2'b00) begin
        total++;
        if (ram_rdata !== dexp[i]) begin
          bad++;
          $display("FAIL alt_data[%0d]: got %h, want %h", i, ram_rdata, dexp[i]);
        end
      end
      step();
    end
  endtask

  task automatic test_reset_midwrite();
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 16'h0100;
    cpu_wdata = 8'h77;
    #1;
    total++;
    if (cpu_gnt !== 1'b1) begin
      bad++;
      $display("FAIL mid_gnt: got %b, want 1", cpu_gnt);
    end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (cpu_gnt !== 1'b0 || ram_address !== 16'h0000 || ram_write_enable !== 1'b0 || ram_wdata !== 8'h00) begin
      bad++;
      $display("FAIL mid_rst: got gnt=%b addr=%h we=%b wdata=%h, want 0/0000/0/00", cpu_gnt, ram_address, ram_write_enable, ram_wdata);
    end
    step();
    total++;
    if (ram_write_enable !== 1'b0 || mem[16'h0100] !== 8'h11 || {dsp_rdata_valid, cpu_rdata_valid} !== 2'b00) begin
      bad++;
      $display("FAIL mid_nowrite: got we=%b mem=%h valids=%b, want 0/11/00", ram_write_enable, mem[16'h0100], {dsp_rdata_valid, cpu_rdata_valid});
    end
    reset = 1'b1;
    #1;
    total++;
    if (cpu_gnt !== 1'b1) begin
      bad++;
      $display("FAIL rel_gnt: got %b, want 1", cpu_gnt);
    end
    step();
    cpu_req = 1'b0;
    #1;
    total++;
    if (ram_write_enable !== 1'b1 || ram_address !== 16'h0100 || ram_wdata !== 8'h77) begin
      bad++;
      $display("FAIL rel_cmd: got we=%b addr=%h wdata=%h, want 1/0100/77", ram_write_enable, ram_address, ram_wdata);
    end
    step();
    total++;
    if (mem[16'h0100] !== 8'h77 || cpu_rdata_valid !== 1'b0) begin
      bad++;
      $display("FAIL rel_mem: got mem=%h valid=%b, want 77/0", mem[16'h0100], cpu_rdata_valid);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b0;
    dsp_req   = 1'b0;
    dsp_addr  = 16'h0000;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 16'h0000;
    cpu_wdata = 8'h00;
    pre_we    = 1'b0;
    pre_addr  = 16'h0000;
    pre_data  = 8'h00;
    pend_d    = 1'b0;
    pend_c    = 1'b0;
    snap_daddr  = 16'h0000;
    snap_caddr  = 16'h0000;
    snap_cwe    = 1'b0;
    snap_cwdata = 8'h00;
`ifdef SPC_RAM_ARB_STATS_EN
    stats_clear = 1'b0;
`endif
    @(posedge clock);
    #1;
    preload(16'h1234, 8'h5A);
    preload(16'h0040, 8'hA4);
    preload(16'h0050, 8'hB5);
    preload(16'h0010, 8'h11);
    preload(16'h0020, 8'h22);
    preload(16'h0030, 8'h33);
    preload(16'h0100, 8'h11);
    preload(16'h00F0, 8'h00);
    test_reset();
    test_dsp_read();
    test_cpu_write_read();
    test_starvation();
    test_alternating();
    test_reset_midwrite();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
